bg_scene_ctrl: RTL
==================

BG_SCENE_CTRL -- requirements
Module: bg_scene_ctrl

Interface
REQ-001 SHALL have parameter RESHAPE_LENGTH, default 320, meaning reshaped background row length in RAM words.
REQ-002 SHALL have parameter BG_ROWS, default 240, meaning reshaped background row count.
REQ-003 SHALL have parameter FADE_FRAMES, default 8, meaning frames of blanking per scene transition (1..15).
REQ-004 SHALL have port Clk, input, 1 bit: system clock; one clock; all state on rising edge.
REQ-005 SHALL have port Reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port DrawX, input, 10 bits: VGA pixel column, 0..639.
REQ-007 SHALL have port DrawY, input, 10 bits: VGA pixel row, 0..479.
REQ-008 SHALL have port start_btn, input, 1 bit: level; request start game.
REQ-009 SHALL have port player_dead, input, 1 bit: level; request game over.
REQ-010 SHALL have port restart_btn, input, 1 bit: level; request return to menu.
REQ-011 SHALL have port scroll_en, input, 1 bit: advance horizontal scroll each frame while in GAME.
REQ-012 SHALL have port scroll_step, input, 4 bits: scroll increment per frame, 0..15.
REQ-013 SHALL have port current_bg, output, 4 bits: background bank select (0 menu, 1 game, 2 over, 4'hf blank).
REQ-014 SHALL have port read_address, output, 19 bits: background RAM read address.
REQ-015 SHALL have port scroll_x, output, 9 bits: current scroll offset, 0..RESHAPE_LENGTH-1.
REQ-016 SHALL have port frame_tick, output, 1 bit: one-cycle pulse at frame start.
REQ-017 SHALL have port busy, output, 1 bit: high while in a FADE state.

Function
REQ-018 SHALL assert frame_tick for exactly one Clk cycle on the first cycle DrawX==0 and DrawY==0, detected by an edge on a registered (0,0) flag; holding (0,0) for multiple cycles yields one pulse.
REQ-019 SHALL implement FSM states MENU, FADE_IN, GAME, FADE_OUT, OVER, FADE_MENU.
REQ-020 SHALL register a request into a one-bit pending flag when MENU sees start_btn, GAME sees player_dead, or OVER sees restart_btn; requests in any FADE state are ignored.
REQ-021 SHALL, on a frame_tick with pending set, clear pending, load fade counter with FADE_FRAMES and go MENU->FADE_IN, GAME->FADE_OUT, OVER->FADE_MENU.
REQ-022 SHALL decrement the fade counter on each frame_tick in a FADE state and, on the tick where counter==1, go FADE_IN->GAME, FADE_OUT->OVER, FADE_MENU->MENU.
REQ-023 SHALL drive current_bg registered: 0 in MENU, 1 in GAME, 2 in OVER, 4'hf in every FADE state; busy high only in FADE states.
REQ-024 SHALL, on frame_tick in GAME with scroll_en high, set scroll_x = scroll_x+scroll_step, subtracting RESHAPE_LENGTH when the sum >= RESHAPE_LENGTH.
REQ-025 SHALL clear scroll_x to 0 on entry into FADE_IN; scroll_x SHALL hold in all other states.
REQ-026 SHALL compute col = DrawX/2 + (current_bg==1 ? scroll_x : 0), subtracting RESHAPE_LENGTH when col >= RESHAPE_LENGTH.
REQ-027 SHALL register read_address = (DrawY/2)*RESHAPE_LENGTH + col with one Clk of latency from DrawX/DrawY.
REQ-028 SHALL clamp read_address to 0 when DrawY/2 >= BG_ROWS or DrawX >= 640.
REQ-029 SHALL give the state transition priority when frame_tick, pending and a new request coincide; the new request is dropped.

Reset
REQ-030 SHALL, while Reset_n is low, immediately force state MENU, pending 0, fade counter 0, scroll_x 0, current_bg 0, read_address 0, frame_tick 0, busy 0, including mid-fade.
REQ-031 SHALL resume normal operation on the first rising Clk edge after Reset_n deasserts, with the first frame_tick at the next (0,0).

Verification
REQ-032 SHALL cover: reset, pulse start_btn mid-frame -> state stays MENU until next (0,0); then current_bg=4'hf, busy=1 for 8 frames; then current_bg=1, busy=0.
REQ-033 SHALL cover: GAME, scroll_en=1, scroll_step=15, scroll_x=310 -> next frame_tick gives scroll_x=5; at DrawX=630, DrawY=2 with scroll_x=5, read_address=320+0=320 one cycle later.
REQ-034 SHALL cover: DrawX=DrawY=0 held for 4 Clk cycles -> exactly one frame_tick pulse.
REQ-035 SHALL cover: player_dead during FADE_IN -> ignored; GAME reached after 8 frames, stays GAME with player_dead low.
REQ-036 SHALL cover: Reset_n low during FADE_OUT frame 3 -> asynchronously current_bg=0, busy=0, scroll_x=0 without a clock edge.
REQ-037 SHALL cover: OVER, restart_btn high -> after next frame_tick plus 8 frames current_bg=0; DrawY=479 -> read_address=239*320+DrawX/2.

Source files
------------

// File: rtl/bg_scene_ctrl.sv
// Background scene controller: menu/game/over scene FSM with timed blanking
// fades between scenes, per-frame horizontal scroll, and background RAM
// read-address generation from the VGA raster position.
module bg_scene_ctrl #(
  parameter int unsigned RESHAPE_LENGTH = 320,
  parameter int unsigned BG_ROWS        = 240,
  parameter int unsigned FADE_FRAMES    = 8
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        start_btn,
  input  logic        player_dead,
  input  logic        restart_btn,
  input  logic        scroll_en,
  input  logic [3:0]  scroll_step,
  output logic [3:0]  current_bg,
  output logic [18:0] read_address,
  output logic [8:0]  scroll_x,
  output logic        frame_tick,
  output logic        busy
);

  typedef enum logic [2:0] {
    MENU,
    FADE_IN,
    GAME,
    FADE_OUT,
    OVER,
    FADE_MENU
  } state_t;

  localparam logic [9:0] ROW_LEN   = 10'(RESHAPE_LENGTH);
  localparam logic [9:0] ROW_COUNT = 10'(BG_ROWS);
  localparam logic [3:0] FADE_INIT = 4'(FADE_FRAMES);

  localparam logic [3:0] BG_MENU  = 4'd0;
  localparam logic [3:0] BG_GAME  = 4'd1;
  localparam logic [3:0] BG_OVER  = 4'd2;
  localparam logic [3:0] BG_BLANK = 4'hf;

  state_t     state;
  logic       pending;
  logic [3:0] fade_cnt;

  // Frame start detection
  logic at_origin;
  logic at_origin_q;

  assign at_origin = (DrawX == '0) && (DrawY == '0);

  // Scroll wrap arithmetic
  logic [9:0] scroll_sum;
  logic [8:0] scroll_next;

  assign scroll_sum  = {1'b0, scroll_x} + {6'b0, scroll_step};
  assign scroll_next = (scroll_sum >= ROW_LEN) ? 9'(scroll_sum - ROW_LEN)
                                               : scroll_sum[8:0];

  // Address arithmetic
  logic [9:0]  half_x;
  logic [9:0]  half_y;
  logic [9:0]  col_sum;
  logic [9:0]  col;
  logic [18:0] addr_next;

  assign half_x  = {1'b0, DrawX[9:1]};
  assign half_y  = {1'b0, DrawY[9:1]};
  assign col_sum = half_x + ((current_bg == BG_GAME) ? {1'b0, scroll_x} : 10'd0);
  assign col     = (col_sum >= ROW_LEN) ? (col_sum - ROW_LEN) : col_sum;

  // Off-screen or beyond the stored rows reads word 0
  assign addr_next = ((half_y >= ROW_COUNT) || (DrawX >= 10'd640))
                     ? '0
                     : (19'(half_y) * 19'(RESHAPE_LENGTH)) + 19'(col);

  // One-cycle frame_tick on the rising edge of the (0,0) flag
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      at_origin_q <= 1'b0;
      frame_tick  <= 1'b0;
    end else begin
      at_origin_q <= at_origin;
      frame_tick  <= at_origin & ~at_origin_q;
    end
  end

  // Scene FSM with registered bank select, busy flag and scroll offset
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= MENU;
      pending    <= 1'b0;
      fade_cnt   <= '0;
      scroll_x   <= '0;
      current_bg <= BG_MENU;
      busy       <= 1'b0;
    end else begin
      case (state)
        MENU: begin
          if (frame_tick && pending) begin
            state      <= FADE_IN;
            pending    <= 1'b0;
            fade_cnt   <= FADE_INIT;
            scroll_x   <= '0;
            current_bg <= BG_BLANK;
            busy       <= 1'b1;
          end else if (start_btn) begin
            pending <= 1'b1;
          end
        end
        GAME: begin
          if (frame_tick && scroll_en) begin
            scroll_x <= scroll_next;
          end
          if (frame_tick && pending) begin
            state      <= FADE_OUT;
            pending    <= 1'b0;
            fade_cnt   <= FADE_INIT;
            current_bg <= BG_BLANK;
            busy       <= 1'b1;
          end else if (player_dead) begin
            pending <= 1'b1;
          end
        end
        OVER: begin
          if (frame_tick && pending) begin
            state      <= FADE_MENU;
            pending    <= 1'b0;
            fade_cnt   <= FADE_INIT;
            current_bg <= BG_BLANK;
            busy       <= 1'b1;
          end else if (restart_btn) begin
            pending <= 1'b1;
          end
        end
        FADE_IN, FADE_OUT, FADE_MENU: begin
          if (frame_tick) begin
            if (fade_cnt == 4'd1) begin
              fade_cnt <= '0;
              busy     <= 1'b0;
              case (state)
                FADE_IN: begin
                  state      <= GAME;
                  current_bg <= BG_GAME;
                end
                FADE_OUT: begin
                  state      <= OVER;
                  current_bg <= BG_OVER;
                end
                default: begin
                  state      <= MENU;
                  current_bg <= BG_MENU;
                end
              endcase
            end else begin
              fade_cnt <= fade_cnt - 4'd1;
            end
          end
        end
        default: begin
          state      <= MENU;
          pending    <= 1'b0;
          fade_cnt   <= '0;
          current_bg <= BG_MENU;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  // Registered RAM read address, one cycle behind DrawX/DrawY
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      read_address <= '0;
    end else begin
      read_address <= addr_next;
    end
  end

endmodule
